hazard_stall_unit: RTL and testbench
====================================

# hazard_stall_unit

Pipeline hazard controller for the pipelined RV32I core. Detects load-use hazards, branch/jump redirects and data-memory wait states. Drives the bubble selector of the ID/EX control multiplexer, plus the PC, IF/ID and ID/EX write enables and the IF/ID flush. It owns multi-cycle stall and flush sequencing and two saturating event counters.

## Interface
Parameters:
- LoadUseCycles, 1, bubble cycles inserted per load-use hazard (1..7)
- FlushCycles, 1, bubble/flush cycles per redirect (1..7)
- CntBits, 16, width of each event counter

Ports:
- clk  input  1  core clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset
- IFID_Rs1_i  input  5  rs1 of instruction in ID
- IFID_Rs2_i  input  5  rs2 of instruction in ID
- IFID_UsesRs1_i  input  1  ID instruction reads rs1
- IFID_UsesRs2_i  input  1  ID instruction reads rs2
- IDEX_Rd_i  input  5  rd of instruction in EX
- IDEX_MemRead_i  input  1  EX instruction is a load
- Redirect_i  input  1  EX resolved taken Branch, Jal or Jalr this cycle
- MemBusy_i  input  1  data memory not ready; freeze pipeline
- Bubble_Sel_o  output  1  1 = control mux forces all 11 control bits to zero
- PC_Write_o  output  1  PC register write enable
- IFID_Write_o  output  1  IF/ID register write enable
- IFID_Flush_o  output  1  IF/ID register cleared to NOP
- IDEX_Write_o  output  1  ID/EX register write enable
- Stall_Count_o  output  CntBits  load-use bubble cycles, saturating
- Flush_Count_o  output  CntBits  redirect flush cycles, saturating

## Operation
- FSM states: RUN, STALL, FLUSH. The down-counter `rem` is 3 bits.
- Hazard condition `lu` is true when all of the following hold:
  - IDEX_MemRead_i is 1
  - IDEX_Rd_i != 0
  - (IDEX_Rd_i == IFID_Rs1_i and IFID_UsesRs1_i) or (IDEX_Rd_i == IFID_Rs2_i and IFID_UsesRs2_i)
- Default outputs: Bubble_Sel_o=0, PC_Write_o=1, IFID_Write_o=1, IFID_Flush_o=0, IDEX_Write_o=1.
- Priority per cycle, highest first: MemBusy_i, then Redirect_i (from any state), then STALL/FLUSH continuation, then new `lu`.
- MemBusy_i=1:
  - PC_Write_o, IFID_Write_o and IDEX_Write_o are 0.
  - Bubble_Sel_o and IFID_Flush_o are 0.
  - State, `rem` and counters hold. All other inputs are ignored.
- Redirect_i=1 (not busy):
  - Bubble_Sel_o=1, IFID_Flush_o=1, PC_Write_o=1.
  - Any pending STALL is abandoned.
  - If FlushCycles>1: next state FLUSH with rem=FlushCycles-1. Otherwise next state RUN.
- FLUSH: Bubble_Sel_o=1, IFID_Flush_o=1, PC_Write_o=1. Decrement `rem`; return to RUN when it reaches 0.
- RUN with `lu` (not busy, no redirect):
  - Bubble_Sel_o=1, PC_Write_o=0, IFID_Write_o=0.
  - If LoadUseCycles>1: next state STALL with rem=LoadUseCycles-1. Otherwise stay in RUN.
- STALL: same outputs as `lu`, independent of `lu`. Decrement `rem`; go to RUN at 0.
- Stall_Count_o increments on every non-busy cycle in which `lu` fires or the state is STALL.
- Flush_Count_o increments on every non-busy Redirect_i or FLUSH cycle.
- Both counters saturate at all-ones and never wrap.

## Timing
- All outputs are combinational from the current state and inputs, so a bubble lands in the same cycle as detection. Zero-cycle latency.
- State, `rem` and counters are registered.
- Reset (reset=0 at a clock edge):
  - State=RUN, rem=0, both counters=0.
  - Outputs settle to the defaults: Bubble_Sel_o=0, PC_Write_o=1, IFID_Write_o=1, IFID_Flush_o=0, IDEX_Write_o=1.
  - Reset mid-STALL or mid-FLUSH aborts the sequence immediately.
- Redirect_i and `lu` in the same cycle: the redirect wins and no stall cycle is counted.
- MemBusy_i during STALL/FLUSH extends the sequence by the busy duration; `rem` does not decrement.

## Structure
- Shared package `pipeline_pkg`:
  - state enum {RUN, STALL, FLUSH}
  - NOP-control constant (11'b0)
  - register-index width constant (5)
- One natural sub-module: `sat_counter` (parameterized width, enable, sync active-low reset). It is instantiated twice.

## Test plan
- Load-use: IDEX_MemRead_i=1, IDEX_Rd_i=5, IFID_Rs1_i=5, IFID_UsesRs1_i=1 for one cycle → Bubble_Sel_o=1, PC_Write_o=0, IFID_Write_o=0 that cycle; Stall_Count_o=1 next cycle.
- x0 and unused operand: IDEX_Rd_i=0, or a matching rs with its Uses flag 0 → no stall, Stall_Count_o stays 0.
- FlushCycles=2, Redirect_i pulse → IFID_Flush_o=1 and Bubble_Sel_o=1 for exactly 2 cycles; Flush_Count_o=2.
- Redirect_i and `lu` together → flush outputs asserted, PC_Write_o=1, Stall_Count_o unchanged.
- LoadUseCycles=3 with MemBusy_i=1 on the second stall cycle → all write enables 0 that cycle, stall lasts 4 cycles total, Stall_Count_o=3.
- CntBits=4, 20 redirects → Flush_Count_o saturates at 15; reset=0 mid-FLUSH → next cycle state RUN, outputs at defaults, counters 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard FSM states, NOP control word, register index width.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hz_state_e;

  localparam logic [10:0] NOP_CTRL  = 11'b0;
  localparam int          REG_IDX_W = 5;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous active-low reset.
module sat_counter #(
  parameter int Width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] cnt_q;
  logic [Width-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != {Width{1'b1}})) begin
      cnt_d = cnt_q + {{(Width-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use / redirect / memory-wait hazard controller with multi-cycle stall
// and flush sequencing and saturating event counters.
module hazard_stall_unit
  import pipeline_pkg::*;
#(
  parameter int LoadUseCycles = 1,
  parameter int FlushCycles   = 1,
  parameter int CntBits       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] IFID_Rs1_i,
  input  logic [REG_IDX_W-1:0] IFID_Rs2_i,
  input  logic                 IFID_UsesRs1_i,
  input  logic                 IFID_UsesRs2_i,
  input  logic [REG_IDX_W-1:0] IDEX_Rd_i,
  input  logic                 IDEX_MemRead_i,
  input  logic                 Redirect_i,
  input  logic                 MemBusy_i,
  output logic                 Bubble_Sel_o,
  output logic                 PC_Write_o,
  output logic                 IFID_Write_o,
  output logic                 IFID_Flush_o,
  output logic                 IDEX_Write_o,
  output logic [CntBits-1:0]   Stall_Count_o,
  output logic [CntBits-1:0]   Flush_Count_o
);

  localparam logic [2:0] LU_REM = 3'(LoadUseCycles - 1);
  localparam logic [2:0] FL_REM = 3'(FlushCycles - 1);

  hz_state_e  state_q, state_d;
  logic [2:0] rem_q, rem_d;
  logic       lu;
  logic       stall_inc;
  logic       flush_inc;

  assign lu = IDEX_MemRead_i && (IDEX_Rd_i != '0) &&
              (((IDEX_Rd_i == IFID_Rs1_i) && IFID_UsesRs1_i) ||
               ((IDEX_Rd_i == IFID_Rs2_i) && IFID_UsesRs2_i));

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    Bubble_Sel_o = 1'b0;
    PC_Write_o   = 1'b1;
    IFID_Write_o = 1'b1;
    IFID_Flush_o = 1'b0;
    IDEX_Write_o = 1'b1;

    if (MemBusy_i) begin
      // Freeze everything; sequencing resumes where it left off.
      PC_Write_o   = 1'b0;
      IFID_Write_o = 1'b0;
      IDEX_Write_o = 1'b0;
    end else if (Redirect_i) begin
      Bubble_Sel_o = 1'b1;
      IFID_Flush_o = 1'b1;
      flush_inc    = 1'b1;
      if (FlushCycles > 1) begin
        state_d = FLUSH;
        rem_d   = FL_REM;
      end else begin
        state_d = RUN;
        rem_d   = 3'd0;
      end
    end else begin
      unique case (state_q)
        FLUSH: begin
          Bubble_Sel_o = 1'b1;
          IFID_Flush_o = 1'b1;
          flush_inc    = 1'b1;
          rem_d        = rem_q - 3'd1;
          if (rem_q <= 3'd1) begin
            state_d = RUN;
            rem_d   = 3'd0;
          end
        end
        STALL: begin
          Bubble_Sel_o = 1'b1;
          PC_Write_o   = 1'b0;
          IFID_Write_o = 1'b0;
          stall_inc    = 1'b1;
          rem_d        = rem_q - 3'd1;
          if (rem_q <= 3'd1) begin
            state_d = RUN;
            rem_d   = 3'd0;
          end
        end
        default: begin
          if (lu) begin
            Bubble_Sel_o = 1'b1;
            PC_Write_o   = 1'b0;
            IFID_Write_o = 1'b0;
            stall_inc    = 1'b1;
            if (LoadUseCycles > 1) begin
              state_d = STALL;
              rem_d   = LU_REM;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      rem_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  sat_counter #(.Width(CntBits)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .en      (stall_inc),
    .count_o (Stall_Count_o)
  );

  sat_counter #(.Width(CntBits)) u_flush_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .en      (flush_inc),
    .count_o (Flush_Count_o)
  );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed scoreboard bench for hazard_stall_unit (LoadUseCycles=3, FlushCycles=2, CntBits=4).
module tb_hazard_stall_unit;

  localparam logic [4:0] DEF = 5'b01101; // {bubble, pc_wr, ifid_wr, ifid_flush, idex_wr}
  localparam logic [4:0] STL = 5'b10001;
  localparam logic [4:0] FLS = 5'b11111;
  localparam logic [4:0] BSY = 5'b00000;

  typedef struct packed {
    logic [4:0] outs;
    logic [3:0] sc;
    logic [3:0] fc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, mr, redir, busy;
  logic       bub, pcw, ifw, ifl, idw;
  logic [3:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  hazard_stall_unit #(
    .LoadUseCycles(3),
    .FlushCycles  (2),
    .CntBits      (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .IFID_Rs1_i     (rs1),
    .IFID_Rs2_i     (rs2),
    .IFID_UsesRs1_i (u1),
    .IFID_UsesRs2_i (u2),
    .IDEX_Rd_i      (rd),
    .IDEX_MemRead_i (mr),
    .Redirect_i     (redir),
    .MemBusy_i      (busy),
    .Bubble_Sel_o   (bub),
    .PC_Write_o     (pcw),
    .IFID_Write_o   (ifw),
    .IFID_Flush_o   (ifl),
    .IDEX_Write_o   (idw),
    .Stall_Count_o  (stall_cnt),
    .Flush_Count_o  (flush_cnt)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, queue the expectation,
  // then sample the combinational outputs and current counters 1 ns later.
  task automatic cyc(input string name, input logic rst,
                     input logic [4:0] a1, input logic [4:0] a2,
                     input logic f1, input logic f2,
                     input logic [4:0] d, input logic m,
                     input logic r, input logic b,
                     input logic [4:0] eo, input logic [3:0] esc, input logic [3:0] efc);
    exp_t e;
    @(negedge clk);
    reset = rst; rs1 = a1; rs2 = a2; u1 = f1; u2 = f2;
    rd = d; mr = m; redir = r; busy = b;
    sb_q.push_back('{outs: eo, sc: esc, fc: efc});
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      chk({name, ".bubble"},    {3'b0, bub}, {3'b0, e.outs[4]});
      chk({name, ".pc_wr"},     {3'b0, pcw}, {3'b0, e.outs[3]});
      chk({name, ".ifid_wr"},   {3'b0, ifw}, {3'b0, e.outs[2]});
      chk({name, ".ifid_fl"},   {3'b0, ifl}, {3'b0, e.outs[1]});
      chk({name, ".idex_wr"},   {3'b0, idw}, {3'b0, e.outs[0]});
      chk({name, ".stall_cnt"}, stall_cnt,   e.sc);
      chk({name, ".flush_cnt"}, flush_cnt,   e.fc);
      $display("cycle %-10s bub=%b pcw=%b ifw=%b fl=%b idw=%b sc=%0d fc=%0d",
               name, bub, pcw, ifw, ifl, idw, stall_cnt, flush_cnt);
    end
  endtask

  // Shorthands: idle, load-use on rs1 of x5, redirect, busy.
  task automatic idle(input string n, input logic [4:0] eo, input logic [3:0] s, input logic [3:0] f);
    cyc(n, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, eo, s, f);
  endtask
  task automatic lu(input string n, input logic [4:0] eo, input logic [3:0] s, input logic [3:0] f);
    cyc(n, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, eo, s, f);
  endtask
  task automatic rdr(input string n, input logic [4:0] eo, input logic [3:0] s, input logic [3:0] f);
    cyc(n, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, eo, s, f);
  endtask
  task automatic bsy(input string n, input logic [4:0] eo, input logic [3:0] s, input logic [3:0] f);
    cyc(n, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, eo, s, f);
  endtask

  initial begin
    reset = 1'b0; rs1 = '0; rs2 = '0; u1 = 0; u2 = 0; rd = '0; mr = 0; redir = 0; busy = 0;
    repeat (2) @(posedge clk);

    // Reset state
    idle("reset", DEF, 0, 0);
    // No-hazard patterns: x0 destination, unused operands, non-load
    cyc("x0",     1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, DEF, 0, 0);
    cyc("unused", 1'b1, 5'd5, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, DEF, 0, 0);
    cyc("noload", 1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, DEF, 0, 0);
    // Load-use via rs2: three bubble cycles
    cyc("lu_rs2", 1'b1, 5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, STL, 0, 0);
    idle("stall1", STL, 1, 0);
    idle("stall2", STL, 2, 0);
    idle("after", DEF, 3, 0);
    // Busy on second stall cycle stretches the stall to four cycles
    lu("lu_b",     STL, 3, 0);
    bsy("busy",    BSY, 4, 0);
    idle("stl_b1", STL, 4, 0);
    idle("stl_b2", STL, 5, 0);
    idle("after_b", DEF, 6, 0);
    // Redirect pulse: two flush cycles
    rdr("redir",  FLS, 6, 0);
    idle("flush1", FLS, 6, 1);
    idle("after_r", DEF, 6, 2);
    // Redirect together with load-use: redirect wins
    cyc("rd_lu",  1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, FLS, 6, 2);
    lu("fl_lu",   FLS, 6, 3);
    idle("after_rl", DEF, 6, 4);
    // Redirect abandons a stall
    lu("lu_s",    STL, 6, 4);
    rdr("rd_stl", FLS, 7, 4);
    idle("flush2", FLS, 7, 5);
    idle("after_s", DEF, 7, 6);
    // Busy in the middle of a flush
    rdr("redir_b", FLS, 7, 6);
    bsy("busy_f",  BSY, 7, 7);
    idle("flush_b", FLS, 7, 7);
    idle("after_f", DEF, 7, 8);
    // Flush counter saturation
    for (int i = 0; i < 20; i++) begin
      rdr($sformatf("rsat%0d", i), FLS, 7, ((8 + i) > 15) ? 4'd15 : 4'(8 + i));
    end
    idle("flush_s", FLS, 7, 15);
    // Stall counter saturation with held load-use
    for (int i = 0; i < 12; i++) begin
      lu($sformatf("lsat%0d", i), STL, ((7 + i) > 15) ? 4'd15 : 4'(7 + i), 15);
    end
    idle("after_sat", DEF, 15, 15);
    // Reset mid-flush
    rdr("redir_r", FLS, 15, 15);
    cyc("rst_fl", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, FLS, 15, 15);
    idle("post_rst", DEF, 0, 0);

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
